seq_divider: RTL and testbench

- Parametrised, clocked integer divider producing quotient and remainder. Next generation of the team's chained three-stage divider.
- Replaces fixed combinational stages and simulation-stop termination with an iterative restoring datapath. Adds a valid/ready handshake on both input and output.
- Adds a selectable signed mode and explicit divide-by-zero reporting.
- Sits between operand-producing logic and any consumer needing A/B results. One operation in flight.

---
 rtl/seq_divider.sv | 158 +++++++++++++++
 tb/tb_seq_divider.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Iterative restoring divider with valid/ready handshakes on both sides.
// Supports optional two's-complement operation and reports divide-by-zero.
module seq_divider #(
  parameter int WIDTH           = 8,
  parameter int STEPS_PER_CYCLE = 1,
  parameter bit SIGNED_EN       = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] div_mag;
  logic             q_neg;
  logic             r_neg;

  logic             eff_signed;
  logic             a_sign;
  logic             b_sign;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             divisor_zero;
  logic             last_cycle;

  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign eff_signed   = signed_mode & SIGNED_EN;
  assign a_sign       = eff_signed & dividend[WIDTH-1];
  assign b_sign       = eff_signed & divisor[WIDTH-1];
  assign a_mag        = a_sign ? -dividend : dividend;
  assign b_mag        = b_sign ? -divisor : divisor;
  assign divisor_zero = (divisor == '0);
  assign last_cycle   = (count == CW'(1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = divisor_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_cycle) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // acc shifts dividend bits out of its top while quotient bits enter at the bottom
  always_comb begin
    step_acc = acc;
    step_rem = part_rem;
    shifted  = '0;
    trial    = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      shifted = {step_rem, step_acc[WIDTH-1]};
      trial   = shifted - {1'b0, div_mag};
      if (!trial[WIDTH]) begin
        step_rem = trial[WIDTH-1:0];
        step_acc = {step_acc[WIDTH-2:0], 1'b1};
      end else begin
        step_rem = shifted[WIDTH-1:0];
        step_acc = {step_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      acc         <= '0;
      part_rem    <= '0;
      div_mag     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              acc      <= a_mag;
              div_mag  <= b_mag;
              part_rem <= '0;
              q_neg    <= a_sign ^ b_sign;
              r_neg    <= a_sign;
              count    <= CW'(N);
            end
          end
        end
        CALC: begin
          acc      <= step_acc;
          part_rem <= step_rem;
          count    <= count - CW'(1);
          if (last_cycle) begin
            quotient    <= q_neg ? -step_acc : step_acc;
            remainder   <= r_neg ? -step_rem : step_rem;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: one-step and two-step-per-cycle instances
// share stimulus so results and latencies of both are checked together.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       signed_mode;
  logic       out_ready;

  logic       in_ready,  out_valid,  div_by_zero;
  logic [7:0] quotient,  remainder;
  logic       in_ready2, out_valid2, div_by_zero2;
  logic [7:0] quotient2, remainder2;

  int tests    = 0;
  int failures = 0;

  localparam int LAT1 = 8;
  localparam int LAT2 = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sgn;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  seq_divider #(.WIDTH(8), .STEPS_PER_CYCLE(1), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  seq_divider #(.WIDTH(8), .STEPS_PER_CYCLE(2), .SIGNED_EN(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .out_valid(out_valid2), .out_ready(out_ready),
    .quotient(quotient2), .remainder(remainder2), .div_by_zero(div_by_zero2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents one operation for a single accepting edge,
  // then counts edges after that edge until each instance raises out_valid.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                               output int lat1, output int lat2);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    dividend    = a;
    divisor     = b;
    signed_mode = sgn;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat1 = -1;
    lat2 = -1;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (out_valid && lat1 < 0) lat1 = c;
      if (out_valid2 && lat2 < 0) lat2 = c;
      if (lat1 >= 0 && lat2 >= 0) break;
    end
  endtask

  task automatic releaseResult(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_ovalid_clr"}, 32'(out_valid), 32'd0);
    checkOutput({name, "_iready_set"}, 32'(in_ready), 32'd1);
    checkOutput({name, "_ovalid2_clr"}, 32'(out_valid2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int l1, l2;

    vecs[0]  = '{8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04, 1'b0};
    vecs[1]  = '{8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0};
    vecs[2]  = '{8'h64, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0};
    vecs[3]  = '{8'h9C, 8'hF9, 1'b1, 8'h0E, 8'hFE, 1'b0};
    vecs[4]  = '{8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1};
    vecs[5]  = '{8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1};
    vecs[6]  = '{8'h09, 8'h03, 1'b0, 8'h03, 8'h00, 1'b0};
    vecs[7]  = '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0};
    vecs[8]  = '{8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0};
    vecs[9]  = '{8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0};
    vecs[10] = '{8'h9C, 8'h07, 1'b0, 8'h16, 8'h02, 1'b0};
    vecs[11] = '{8'hFF, 8'hFF, 1'b1, 8'h01, 8'h00, 1'b0};
    vecs[12] = '{8'h07, 8'h09, 1'b0, 8'h00, 8'h07, 1'b0};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    dividend    = '0;
    divisor     = '0;
    signed_mode = 1'b0;
    out_ready   = 1'b0;

    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_quotient", 32'(quotient), 32'd0);
    checkOutput("rst_remainder", 32'(remainder), 32'd0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, l1, l2);
      checkOutput($sformatf("v%0d_q", i), 32'(quotient), 32'(vecs[i].q));
      checkOutput($sformatf("v%0d_r", i), 32'(remainder), 32'(vecs[i].r));
      checkOutput($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dz));
      checkOutput($sformatf("v%0d_q2", i), 32'(quotient2), 32'(vecs[i].q));
      checkOutput($sformatf("v%0d_r2", i), 32'(remainder2), 32'(vecs[i].r));
      checkOutput($sformatf("v%0d_dbz2", i), 32'(div_by_zero2), 32'(vecs[i].dz));
      checkOutput($sformatf("v%0d_lat", i), 32'(l1), vecs[i].dz ? 32'd0 : 32'(LAT1));
      checkOutput($sformatf("v%0d_lat2", i), 32'(l2), vecs[i].dz ? 32'd0 : 32'(LAT2));
      releaseResult($sformatf("v%0d", i));
    end

    // Backpressure: result held while new operands are offered and ignored
    applyStimulus(8'hC8, 8'h07, 1'b0, l1, l2);
    checkOutput("bp_lat", 32'(l1), 32'(LAT1));
    dividend    = 8'h0F;
    divisor     = 8'h04;
    signed_mode = 1'b0;
    in_valid    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_ovalid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp%0d_iready", c), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp%0d_q", c), 32'(quotient), 32'h1C);
      checkOutput($sformatf("bp%0d_r", c), 32'(remainder), 32'h04);
      checkOutput($sformatf("bp%0d_dbz", c), 32'(div_by_zero), 32'd0);
    end
    in_valid = 1'b0;
    releaseResult("bp");
    checkOutput("bp_q_kept", 32'(quotient), 32'h1C);
    checkOutput("bp_r_kept", 32'(remainder), 32'h04);

    // Reset mid-operation aborts without producing a result
    dividend    = 8'hC8;
    divisor     = 8'h07;
    signed_mode = 1'b0;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_busy", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ovalid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ovalid2", 32'(out_valid2), 32'd0);
    checkOutput("mid_rst_q", 32'(quotient), 32'd0);
    checkOutput("mid_rst_r", 32'(remainder), 32'd0);
    checkOutput("mid_rst_iready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_ovalid", 32'(out_valid), 32'd0);
    applyStimulus(8'h0F, 8'h04, 1'b0, l1, l2);
    checkOutput("post_rst_q", 32'(quotient), 32'd3);
    checkOutput("post_rst_r", 32'(remainder), 32'd3);
    checkOutput("post_rst_lat", 32'(l1), 32'(LAT1));
    checkOutput("post_rst_q2", 32'(quotient2), 32'd3);
    releaseResult("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
